hazard_ctrl: RTL
================

# hazard_ctrl

Scoreboard-based hazard controller that sequences the decode stage against the in-order execute/memory/writeback pipeline. It mirrors every issued instruction's destination register and CSR-write intent through three tracking slots, and raises `stall` while the instruction in decode reads a GPR or CSR that an older in-flight instruction has not yet written. It sits beside the decode stage; its `stall` feeds the decode bubble-insertion path and the fetch hold.

## Interface
- `NSLOT`, 3: tracking depth; S1 = execute, S2 = memory, S3 = writeback. Fixed at 3.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decode holds a valid instruction.
- `issue_ra1`, `issue_ra2`  in  5 each  source register addresses.
- `issue_ra1_used`, `issue_ra2_used`  in  1 each  source actually read.
- `issue_dst`  in  5  destination register.
- `issue_wen`  in  1  instruction writes `issue_dst`.
- `issue_csr_rd`  in  1  reads a CSR (includes exception/mret mstatus read).
- `issue_csr_wen`  in  1  writes a CSR.
- `advance`  in  1  pipeline shifts one stage this cycle; low while memory is busy.
- `flush`  in  1  kills decode instruction and S1 (redirect from execute).
- `stall`  out  1  hold decode/fetch; insert bubble.
- `busy_mask`  out  32  bit r set when any valid slot writes xr; bit 0 always 0.
- `inflight`  out  2  number of valid slots (0..3).

## Operation
- Slot contents: `v`, `dst[4:0]`, `wen`, `csr_wen`. An entry with `dst==0` is stored with `wen=0`.
- GPR hazard: `issue_rax_used && issue_rax!=0 && ∃ slot: v && wen && dst==issue_rax`.
- CSR hazard: `issue_csr_rd && ∃ slot: v && csr_wen`. No CSR address comparison; all CSR writes serialise.
- `stall = issue_valid && !flush && (GPR hazard || CSR hazard)`. Combinational from inputs and slot state.
- No forwarding: S3 is a hazard because the register file writes at the end of writeback.
- `issue_fire = issue_valid && !stall && !flush && advance`.
- Slot update at posedge, in priority order:
  - `reset`: all slots `v=0`, fields 0.
  - `advance`: S3←S2, S2←S1, S1←issue fields with `v=issue_fire`. If `flush`, S1 loads invalid, and the old S1 contents are discarded instead of moving to S2.
  - `!advance`: all slots hold. If `flush`, S1←invalid.
- `busy_mask` and `inflight` are combinational from the slot registers.
- A stalled instruction re-evaluates every cycle. `stall` drops in the cycle after the producing slot shifts out of S3.

## Timing
- Reset values: all slots invalid; `stall=0`, `busy_mask=0`, `inflight=0`. Values are valid in the first cycle after `reset` deasserts.
- Issue latency: an instruction firing in cycle t occupies S1 at t+1, S2 at t+2, S3 at t+3, and leaves at t+4, provided `advance` stays high.
- Dependent instruction with `advance` continuously high: `stall` is high for exactly 3 cycles, and it fires in the 4th.
- `advance=0`: slots freeze and stall duration extends 1:1.
- `flush` and `stall` in the same cycle: `stall=0`, nothing is issued, and S1 is killed.
- `flush` with `advance=0`: S1 is cleared, and S2/S3 hold.
- Reset mid-operation: all in-flight tracking is lost. The pipeline is reset in the same cycle by contract.
- Two in-flight writers to the same register: either one matching is enough to raise `stall`. No counter saturation exists.

## Test plan
- RAW chain: issue `addi x5` (wen, dst=5), then issue `add` reading ra1=5, `advance=1` throughout → `stall=1` for cycles t+1..t+3, the second instruction fires at t+4, and `busy_mask[5]=1` over t+1..t+3.
- x0 immunity: writer with dst=0, then a reader of ra1=0 → `stall` never asserts, and `busy_mask=0`.
- Memory freeze: writer to x7 enters S2, `advance=0` for 5 cycles, reader of x7 waiting → `stall` stays high for those 5 cycles plus the remaining 2, and `inflight` holds at 1.
- Flush: writer to x9 in S1 with `flush=1` and `advance=1` → the next cycle shows `busy_mask[9]=0`; a reader of x9 fires without stall.
- CSR serialisation: `csrw` (csr_wen) issued, followed by `csrr` (csr_rd) → `stall` for 3 cycles. A following non-CSR instruction reading unrelated registers never stalls.
- Reset mid-flight: 3 valid slots, pulse `reset` → the next cycle shows `inflight=0`, `busy_mask=0`, `stall=0`.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Scoreboard hazard controller: tracks destination/CSR-write intent of in-flight
// instructions through execute, memory and writeback, and stalls decode on RAW hazards.
module hazard_ctrl #(
   parameter int NSLOT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic [4:0]  issue_ra1,
   input  logic [4:0]  issue_ra2,
   input  logic        issue_ra1_used,
   input  logic        issue_ra2_used,
   input  logic [4:0]  issue_dst,
   input  logic        issue_wen,
   input  logic        issue_csr_rd,
   input  logic        issue_csr_wen,
   input  logic        advance,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] busy_mask,
   output logic [1:0]  inflight
);

   // Slot 0 = execute, 1 = memory, 2 = writeback.
   logic       r_v   [NSLOT];
   logic [4:0] r_dst [NSLOT];
   logic       r_wen [NSLOT];
   logic       r_csr [NSLOT];

   logic w_gpr_haz;
   logic w_csr_haz;
   logic w_fire;

   always_comb begin
      w_gpr_haz = 1'b0;
      w_csr_haz = 1'b0;
      busy_mask = '0;
      inflight  = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (r_v[i] && r_wen[i]) begin
            busy_mask[r_dst[i]] = 1'b1;
            if (issue_ra1_used && (issue_ra1 != 5'd0) && (r_dst[i] == issue_ra1))
               w_gpr_haz = 1'b1;
            if (issue_ra2_used && (issue_ra2 != 5'd0) && (r_dst[i] == issue_ra2))
               w_gpr_haz = 1'b1;
         end
         if (r_v[i] && r_csr[i] && issue_csr_rd)
            w_csr_haz = 1'b1;
         inflight = inflight + {1'b0, r_v[i]};
      end
      busy_mask[0] = 1'b0;
   end

   // No forwarding: writeback still counts, the register file commits at its end.
   assign stall  = issue_valid && !flush && (w_gpr_haz || w_csr_haz);
   assign w_fire = issue_valid && !stall && !flush && advance;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSLOT; i++) begin
            r_v[i]   <= 1'b0;
            r_dst[i] <= '0;
            r_wen[i] <= 1'b0;
            r_csr[i] <= 1'b0;
         end
      end else if (advance) begin
         for (int i = NSLOT - 1; i >= 2; i--) begin
            r_v[i]   <= r_v[i-1];
            r_dst[i] <= r_dst[i-1];
            r_wen[i] <= r_wen[i-1];
            r_csr[i] <= r_csr[i-1];
         end
         // A flushed execute entry is dropped rather than moving into memory.
         r_v[1]   <= r_v[0] && !flush;
         r_dst[1] <= r_dst[0];
         r_wen[1] <= r_wen[0];
         r_csr[1] <= r_csr[0];
         r_v[0]   <= w_fire;
         r_dst[0] <= w_fire ? issue_dst : 5'd0;
         r_wen[0] <= w_fire && issue_wen && (issue_dst != 5'd0);
         r_csr[0] <= w_fire && issue_csr_wen;
      end else if (flush) begin
         r_v[0]   <= 1'b0;
         r_dst[0] <= '0;
         r_wen[0] <= 1'b0;
         r_csr[0] <= 1'b0;
      end
   end

endmodule
